// File: rtl/dadd_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | dadd_pkg : state, pass-type constants and helpers for dadd_seq         |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
package dadd_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    D_FRAC  = 3'd1,
    D_INT   = 3'd2,
    D_SHADE = 3'd3,
    Z_FRAC  = 3'd4,
    Z_INT   = 3'd5,
    ACK     = 3'd6
  } state_t;

  localparam logic PASS_FRAC = 1'b0;
  localparam logic PASS_INT  = 1'b1;

  // Adder pass state for a requester (data or Z) and pass type.
  function automatic state_t pass_state(input logic is_z, input logic pass);
    state_t s;
    case ({is_z, pass})
      2'b00:   s = D_FRAC;
      2'b01:   s = D_INT;
      2'b10:   s = Z_FRAC;
      default: s = Z_INT;
    endcase
    return s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dadd_arb.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | dadd_arb : fixed-priority pick between data and Z adder requesters     |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
module dadd_arb #(
  parameter bit ZFIRST = 1'b1
) (
  input  logic dpend,
  input  logic zpend,
  output logic grant_d,
  output logic grant_z
);

  generate
    if (ZFIRST) begin : g_zfirst
      assign grant_z = zpend;
      assign grant_d = dpend & ~zpend;
    end else begin : g_dfirst
      assign grant_d = dpend;
      assign grant_z = zpend & ~dpend;
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/dadd_seq.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | dadd_seq : sequences shared data adder passes for data and Z writes    |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
module dadd_seq #(
  parameter bit FRAC_EN = 1'b1,
  parameter bit ZFIRST  = 1'b1
) (
  input  logic sys_clk,
  input  logic reset,
  input  logic cmdld,
  input  logic gourd_en,
  input  logic gourz_en,
  input  logic shade_en,
  input  logic dreq,
  input  logic zreq,
  input  logic hold,
  output logic dwrite,
  output logic dzwrite,
  output logic atick_0,
  output logic atick_1,
  output logic dack,
  output logic zack,
  output logic busy,
  output logic ovf
);

  import dadd_pkg::*;

  localparam logic c_first_pass = FRAC_EN ? PASS_FRAC : PASS_INT;

  state_t r_state;
  state_t w_state_nxt;
  logic   r_cur_z;
  logic   w_cur_z_nxt;
  logic   r_dpend;
  logic   r_zpend;
  logic   r_gourd;
  logic   r_gourz;
  logic   r_shade;
  logic   w_in_ack;
  logic   w_clr_d;
  logic   w_clr_z;
  logic   w_cand_d;
  logic   w_cand_z;
  logic   w_grant_d;
  logic   w_grant_z;
  logic   w_ovf_set;

  assign w_in_ack = (r_state == ACK);
  assign w_clr_d  = w_in_ack & ~r_cur_z & ~hold;
  assign w_clr_z  = w_in_ack &  r_cur_z & ~hold;

  // The requester being acknowledged cannot restart from its own ACK cycle.
  assign w_cand_d = r_dpend & ~(w_in_ack & ~r_cur_z);
  assign w_cand_z = r_zpend & ~(w_in_ack &  r_cur_z);

  assign w_ovf_set = (dreq & r_dpend & ~w_clr_d) | (zreq & r_zpend & ~w_clr_z);

  dadd_arb #(
    .ZFIRST (ZFIRST)
  ) u_arb (
    .dpend   (w_cand_d),
    .zpend   (w_cand_z),
    .grant_d (w_grant_d),
    .grant_z (w_grant_z)
  );

  // The whole pass path is chosen at start and encoded in the state, so a
  // cmdld during a sequence cannot alter the request already in flight.
  always_comb begin
    w_state_nxt = r_state;
    w_cur_z_nxt = r_cur_z;
    if (!hold) begin
      case (r_state)
        IDLE, ACK: begin
          w_state_nxt = IDLE;
          if (w_grant_z) begin
            w_cur_z_nxt = 1'b1;
            w_state_nxt = r_gourz ? pass_state(1'b1, c_first_pass) : ACK;
          end else if (w_grant_d) begin
            w_cur_z_nxt = 1'b0;
            if (r_gourd)      w_state_nxt = pass_state(1'b0, c_first_pass);
            else if (r_shade) w_state_nxt = D_SHADE;
            else              w_state_nxt = ACK;
          end
        end
        D_FRAC:                 w_state_nxt = D_INT;
        Z_FRAC:                 w_state_nxt = Z_INT;
        D_INT, D_SHADE, Z_INT:  w_state_nxt = ACK;
        default:                w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cur_z <= 1'b0;
      r_dpend <= 1'b0;
      r_zpend <= 1'b0;
      r_gourd <= 1'b0;
      r_gourz <= 1'b0;
      r_shade <= 1'b0;
      ovf     <= 1'b0;
      dwrite  <= 1'b0;
      dzwrite <= 1'b0;
      atick_0 <= 1'b0;
      atick_1 <= 1'b0;
      dack    <= 1'b0;
      zack    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cur_z <= w_cur_z_nxt;
      r_dpend <= (r_dpend & ~w_clr_d) | dreq;
      r_zpend <= (r_zpend & ~w_clr_z) | zreq;
      if (cmdld) begin
        r_gourd <= gourd_en;
        r_gourz <= gourz_en;
        r_shade <= shade_en;
        ovf     <= 1'b0;
      end else if (w_ovf_set) begin
        ovf <= 1'b1;
      end
      dwrite  <= (w_state_nxt == D_FRAC) | (w_state_nxt == D_INT) | (w_state_nxt == D_SHADE);
      dzwrite <= (w_state_nxt == Z_FRAC) | (w_state_nxt == Z_INT);
      atick_0 <= (w_state_nxt == D_FRAC) | (w_state_nxt == Z_FRAC);
      atick_1 <= (w_state_nxt == D_INT)  | (w_state_nxt == Z_INT);
      dack    <= (w_state_nxt == ACK) & ~w_cur_z_nxt;
      zack    <= (w_state_nxt == ACK) &  w_cur_z_nxt;
    end
  end

  assign busy = (r_state != IDLE) | r_dpend | r_zpend;

endmodule
`default_nettype wire

// File: tb/tb_dadd_seq.sv
`default_nettype none
// Bench for dadd_seq: three builds (default, FRAC_EN=0, ZFIRST=0) on shared
// stimulus, directed scenarios plus random traffic against a job-queue model.
module tb_dadd_seq;

  // Output word layout: {dwrite, dzwrite, atick_0, atick_1, dack, zack}
  localparam logic [5:0] W_DFRAC = 6'b101000;
  localparam logic [5:0] W_DINT  = 6'b100100;
  localparam logic [5:0] W_DSH   = 6'b100000;
  localparam logic [5:0] W_ZFRAC = 6'b011000;
  localparam logic [5:0] W_ZINT  = 6'b010100;
  localparam logic [5:0] W_DACK  = 6'b000010;
  localparam logic [5:0] W_ZACK  = 6'b000001;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset = 1'b1, cmdld = 1'b0, gourd_en = 1'b0, gourz_en = 1'b0, shade_en = 1'b0;
  logic dreq = 1'b0, zreq = 1'b0, hold = 1'b0;
  logic [2:0] dw, dzw, a0, a1, dk, zk, bz, ov;

  int n_tests = 0;
  int n_fail  = 0;

  dadd_seq #(.FRAC_EN(1'b1), .ZFIRST(1'b1)) u_dut0 (
    .sys_clk(clk), .reset(reset), .cmdld(cmdld), .gourd_en(gourd_en), .gourz_en(gourz_en),
    .shade_en(shade_en), .dreq(dreq), .zreq(zreq), .hold(hold), .dwrite(dw[0]), .dzwrite(dzw[0]),
    .atick_0(a0[0]), .atick_1(a1[0]), .dack(dk[0]), .zack(zk[0]), .busy(bz[0]), .ovf(ov[0]));

  dadd_seq #(.FRAC_EN(1'b0), .ZFIRST(1'b1)) u_dut1 (
    .sys_clk(clk), .reset(reset), .cmdld(cmdld), .gourd_en(gourd_en), .gourz_en(gourz_en),
    .shade_en(shade_en), .dreq(dreq), .zreq(zreq), .hold(hold), .dwrite(dw[1]), .dzwrite(dzw[1]),
    .atick_0(a0[1]), .atick_1(a1[1]), .dack(dk[1]), .zack(zk[1]), .busy(bz[1]), .ovf(ov[1]));

  dadd_seq #(.FRAC_EN(1'b1), .ZFIRST(1'b0)) u_dut2 (
    .sys_clk(clk), .reset(reset), .cmdld(cmdld), .gourd_en(gourd_en), .gourz_en(gourz_en),
    .shade_en(shade_en), .dreq(dreq), .zreq(zreq), .hold(hold), .dwrite(dw[2]), .dzwrite(dzw[2]),
    .atick_0(a0[2]), .atick_1(a1[2]), .dack(dk[2]), .zack(zk[2]), .busy(bz[2]), .ovf(ov[2]));

  function automatic logic [5:0] obs(input int m);
    return {dw[m], dzw[m], a0[m], a1[m], dk[m], zk[m]};
  endfunction

  // Reference model: a started request becomes a list of output words, one
  // per non-held cycle, ending in its acknowledge word.
  logic [5:0] mcur[3] = '{default: 6'd0};
  logic [5:0] mq[3][$];
  bit mdp[3], mzp[3], mov[3], mgd[3], mgz[3], msh[3];

  task automatic model_step(input int m);
    bit fe, zf, ackd, ackz, pd, pz;
    logic [5:0] c;
    fe = (m != 1);
    zf = (m != 2);
    c  = mcur[m];
    if (reset) begin
      mcur[m] = 6'd0; mq[m].delete();
      mdp[m] = 0; mzp[m] = 0; mov[m] = 0; mgd[m] = 0; mgz[m] = 0; msh[m] = 0;
      return;
    end
    ackd = !hold && (c == W_DACK);
    ackz = !hold && (c == W_ZACK);
    if (!hold) begin
      if (mq[m].size() != 0) begin
        mcur[m] = mq[m].pop_front();
      end else begin
        pd = mdp[m] && (c != W_DACK);
        pz = mzp[m] && (c != W_ZACK);
        if (pz && (zf || !pd)) begin
          if (mgz[m]) begin
            if (fe) mq[m].push_back(W_ZFRAC);
            mq[m].push_back(W_ZINT);
          end
          mq[m].push_back(W_ZACK);
          mcur[m] = mq[m].pop_front();
        end else if (pd) begin
          if (mgd[m]) begin
            if (fe) mq[m].push_back(W_DFRAC);
            mq[m].push_back(W_DINT);
          end else if (msh[m]) begin
            mq[m].push_back(W_DSH);
          end
          mq[m].push_back(W_DACK);
          mcur[m] = mq[m].pop_front();
        end else begin
          mcur[m] = 6'd0;
        end
      end
    end
    if (cmdld) mov[m] = 0;
    else if ((dreq && mdp[m] && !ackd) || (zreq && mzp[m] && !ackz)) mov[m] = 1;
    mdp[m] = (mdp[m] && !ackd) || dreq;
    mzp[m] = (mzp[m] && !ackz) || zreq;
    if (cmdld) begin
      mgd[m] = gourd_en; mgz[m] = gourz_en; msh[m] = shade_en;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    for (int m = 0; m < 3; m++) model_step(m);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1; cmdld = 0; dreq = 0; zreq = 0; hold = 0;
    tick(); tick();
    reset = 0;
  endtask

  task automatic load_cmd(input logic gd, input logic gz, input logic sh);
    cmdld = 1; gourd_en = gd; gourz_en = gz; shade_en = sh;
    tick();
    cmdld = 0;
  endtask

  task automatic test_reset();
    apply_reset();
    n_tests++; if (obs(0) !== 6'd0) begin n_fail++; $display("FAIL reset_outputs got=%b exp=%b", obs(0), 6'd0); end
    n_tests++; if (bz !== 3'b000) begin n_fail++; $display("FAIL reset_busy got=%b exp=000", bz); end
    n_tests++; if (ov !== 3'b000) begin n_fail++; $display("FAIL reset_ovf got=%b exp=000", ov); end
  endtask

  task automatic test_gouraud();
    apply_reset(); load_cmd(1'b1, 1'b0, 1'b0);
    dreq = 1; tick(); dreq = 0;
    tick();
    n_tests++; if (obs(0) !== W_DFRAC) begin n_fail++; $display("FAIL gouraud_frac got=%b exp=%b", obs(0), W_DFRAC); end
    tick();
    n_tests++; if (obs(0) !== W_DINT) begin n_fail++; $display("FAIL gouraud_int got=%b exp=%b", obs(0), W_DINT); end
    tick();
    n_tests++; if (obs(0) !== W_DACK) begin n_fail++; $display("FAIL gouraud_ack got=%b exp=%b", obs(0), W_DACK); end
    tick();
    n_tests++; if ({bz[0], obs(0)} !== 7'd0) begin n_fail++; $display("FAIL gouraud_idle got=%b exp=0", {bz[0], obs(0)}); end
  endtask

  task automatic test_simultaneous();
    logic [5:0] e0[6] = '{W_ZFRAC, W_ZINT, W_ZACK, W_DFRAC, W_DINT, W_DACK};
    logic [5:0] e2[6] = '{W_DFRAC, W_DINT, W_DACK, W_ZFRAC, W_ZINT, W_ZACK};
    apply_reset(); load_cmd(1'b1, 1'b1, 1'b0);
    dreq = 1; zreq = 1; tick(); dreq = 0; zreq = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_tests++; if (obs(0) !== e0[i]) begin n_fail++; $display("FAIL simul_zfirst step%0d got=%b exp=%b", i, obs(0), e0[i]); end
      n_tests++; if (obs(2) !== e2[i]) begin n_fail++; $display("FAIL simul_dfirst step%0d got=%b exp=%b", i, obs(2), e2[i]); end
    end
    tick();
    n_tests++; if (bz !== 3'b000) begin n_fail++; $display("FAIL simul_busy got=%b exp=000", bz); end
  endtask

  task automatic test_shade();
    apply_reset(); load_cmd(1'b0, 1'b0, 1'b1);
    dreq = 1; tick(); dreq = 0;
    tick();
    n_tests++; if (obs(0) !== W_DSH) begin n_fail++; $display("FAIL shade_pass got=%b exp=%b", obs(0), W_DSH); end
    tick();
    n_tests++; if (obs(0) !== W_DACK) begin n_fail++; $display("FAIL shade_ack got=%b exp=%b", obs(0), W_DACK); end
  endtask

  task automatic test_hold();
    apply_reset(); load_cmd(1'b1, 1'b0, 1'b0);
    dreq = 1; tick(); dreq = 0;
    tick();
    hold = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_tests++; if (obs(0) !== W_DFRAC) begin n_fail++; $display("FAIL hold_frac cyc%0d got=%b exp=%b", i, obs(0), W_DFRAC); end
    end
    hold = 0;
    tick();
    n_tests++; if (obs(0) !== W_DINT) begin n_fail++; $display("FAIL hold_int got=%b exp=%b", obs(0), W_DINT); end
    tick();
    n_tests++; if (obs(0) !== W_DACK) begin n_fail++; $display("FAIL hold_ack got=%b exp=%b", obs(0), W_DACK); end
  endtask

  task automatic test_overflow_reset();
    int acks;
    apply_reset(); load_cmd(1'b1, 1'b1, 1'b0);
    dreq = 1; tick(); tick(); dreq = 0;
    tick();
    n_tests++; if (ov[0] !== 1'b1) begin n_fail++; $display("FAIL ovf_set got=%b exp=1", ov[0]); end
    acks = 0;
    for (int i = 0; i < 8; i++) begin tick(); acks += dk[0]; end
    n_tests++; if (acks != 1) begin n_fail++; $display("FAIL ovf_single_dack got=%0d exp=1", acks); end
    zreq = 1; tick(); zreq = 0;
    tick(); tick();
    n_tests++; if (obs(0) !== W_ZINT) begin n_fail++; $display("FAIL rst_pre_zint got=%b exp=%b", obs(0), W_ZINT); end
    reset = 1; tick(); reset = 0;
    n_tests++; if ({ov[0], bz[0], obs(0)} !== 8'd0) begin n_fail++; $display("FAIL rst_mid_clear got=%b exp=0", {ov[0], bz[0], obs(0)}); end
    acks = 0;
    for (int i = 0; i < 4; i++) begin tick(); acks += zk[0]; end
    n_tests++; if (acks != 0) begin n_fail++; $display("FAIL rst_no_zack got=%0d exp=0", acks); end
  endtask

  task automatic test_frac_disabled();
    apply_reset(); load_cmd(1'b0, 1'b1, 1'b0);
    zreq = 1; tick(); zreq = 0;
    tick();
    n_tests++; if (obs(1) !== W_ZINT) begin n_fail++; $display("FAIL nofrac_zint got=%b exp=%b", obs(1), W_ZINT); end
    tick();
    n_tests++; if (obs(1) !== W_ZACK) begin n_fail++; $display("FAIL nofrac_zack got=%b exp=%b", obs(1), W_ZACK); end
  endtask

  task automatic test_cmd_midflight();
    apply_reset(); load_cmd(1'b1, 1'b0, 1'b0);
    dreq = 1; tick(); dreq = 0;
    tick();
    load_cmd(1'b0, 1'b0, 1'b1);
    n_tests++; if (obs(0) !== W_DINT) begin n_fail++; $display("FAIL midcmd_int got=%b exp=%b", obs(0), W_DINT); end
    tick();
    dreq = 1; tick(); dreq = 0;
    tick();
    n_tests++; if (obs(0) !== W_DSH) begin n_fail++; $display("FAIL midcmd_newshade got=%b exp=%b", obs(0), W_DSH); end
  endtask

  task automatic test_random();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      reset = ($urandom_range(199) == 0);
      cmdld = ($urandom_range(15) == 0);
      gourd_en = $urandom_range(1); gourz_en = $urandom_range(1); shade_en = $urandom_range(1);
      dreq = ($urandom_range(3) == 0);
      zreq = ($urandom_range(3) == 0);
      hold = ($urandom_range(4) == 0);
      tick();
      for (int m = 0; m < 3; m++) begin
        n_tests++; if (obs(m) !== mcur[m]) begin n_fail++; $display("FAIL rand_out dut%0d cyc%0d got=%b exp=%b", m, cyc, obs(m), mcur[m]); end
        n_tests++; if (bz[m] !== (mcur[m] != 0 || mdp[m] || mzp[m])) begin n_fail++; $display("FAIL rand_busy dut%0d cyc%0d got=%b", m, cyc, bz[m]); end
        n_tests++; if (ov[m] !== mov[m]) begin n_fail++; $display("FAIL rand_ovf dut%0d cyc%0d got=%b exp=%b", m, cyc, ov[m], mov[m]); end
      end
    end
    reset = 0; cmdld = 0; dreq = 0; zreq = 0; hold = 0;
  endtask

  initial begin
    test_reset();
    test_gouraud();
    test_simultaneous();
    test_shade();
    test_hold();
    test_overflow_reset();
    test_frac_disabled();
    test_cmd_midflight();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
